// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the shared JK bank arbiter.
//   req_valid [NREQ]        : per-requester command valid
//   req_cmd   [2*NREQ]      : requester i command at [2i+1:2i] (00 hold, 01 reset, 10 set, 11 toggle)
//   req_mask  [WIDTH*NREQ]  : requester i bit mask at [WIDTH*i +: WIDTH]
//   req_ready [NREQ]        : one-hot, one-cycle accept pulse to the granted requester
// master = requester side, slave = arbiter side.
interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_cmd;
   logic [WIDTH*NREQ-1:0] req_mask;
   logic [NREQ-1:0]       req_ready;

   modport master (output req_valid, req_cmd, req_mask, input req_ready);
   modport slave  (input req_valid, req_cmd, req_mask, output req_ready);
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit JK flip-flop bank
// between NREQ requesters. One command is granted per IDLE->DRIVE->IDLE pass:
// the grant edge latches the masked J/K drive, the closing edge applies it to q.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : req_valid / req_cmd / req_mask in, req_ready out
//   j_out, k_out  : registered J/K drive (non-zero only during DRIVE)
//   q             : JK bank state
//   grant_id      : current or last granted requester
//   busy          : high while in DRIVE
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   jk_bank_arbiter_if.slave bus,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic [WIDTH-1:0] q,
   output logic [IDW-1:0]   grant_id,
   output logic             busy
);
   typedef enum logic {IDLE, DRIVE} state_t;

   state_t state, state_nxt;

   logic [IDW-1:0]   rr_ptr, rr_nxt, grant_nxt;
   logic [NREQ-1:0]  ready_r, ready_nxt;
   logic [WIDTH-1:0] j_nxt, k_nxt, q_nxt;
   logic             busy_nxt;

   // Per-requester views of the flat command/mask buses.
   logic [NREQ-1:0][1:0]       cmd_a;
   logic [NREQ-1:0][WIDTH-1:0] mask_a;
   assign cmd_a  = bus.req_cmd;
   assign mask_a = bus.req_mask;

   assign bus.req_ready = ready_r;

   // Round-robin pick: scanning offsets from high to low lets the smallest
   // offset from rr_ptr win, giving "first valid upward from the pointer".
   logic           found;
   logic [IDW-1:0] sel;
   always_comb begin
      logic [IDW-1:0] idx;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         idx = IDW'((int'(rr_ptr) + i) % NREQ);
         if (bus.req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Command bit 1 drives J, bit 0 drives K; unmasked bits hold.
   logic [1:0]       cmd_sel;
   logic [WIDTH-1:0] mask_sel;
   assign cmd_sel  = cmd_a[sel];
   assign mask_sel = mask_a[sel];

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      grant_nxt = grant_id;
      ready_nxt = '0;
      j_nxt     = '0;
      k_nxt     = '0;
      busy_nxt  = 1'b0;
      q_nxt     = q;
      case (state)
         IDLE: begin
            if (found) begin
               j_nxt          = {WIDTH{cmd_sel[1]}} & mask_sel;
               k_nxt          = {WIDTH{cmd_sel[0]}} & mask_sel;
               ready_nxt[sel] = 1'b1;
               grant_nxt      = sel;
               busy_nxt       = 1'b1;
               state_nxt      = DRIVE;
            end
         end
         DRIVE: begin
            q_nxt     = (j_out & ~q) | (~k_out & q);
            rr_nxt    = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         ready_r  <= '0;
         j_out    <= '0;
         k_out    <= '0;
         busy     <= 1'b0;
         q        <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         grant_id <= grant_nxt;
         ready_r  <= ready_nxt;
         j_out    <= j_nxt;
         k_out    <= k_nxt;
         busy     <= busy_nxt;
         q        <= q_nxt;
      end
   end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: table-driven single commands with a
// scoreboard of expected grant/drive/state, plus hand sequences for reset,
// contention, round-robin wrap and reset during DRIVE.
module tb_jk_bank_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   logic [WIDTH-1:0] j_out, k_out, q;
   logic [IDW-1:0]   grant_id;
   logic             busy;

   jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .j_out    (j_out),
      .k_out    (k_out),
      .q        (q),
      .grant_id (grant_id),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         req;
      logic [1:0] cmd;
      logic [7:0] mask;
      logic [3:0] ready;
      logic [1:0] grant;
      logic [7:0] j, k, q;
   } vec_t;

   typedef struct {
      logic [3:0] ready;
      logic [1:0] grant;
      logic [7:0] j, k, q;
   } exp_t;

   exp_t       sb[$];
   bit         sb_en  = 1'b0;
   bit         q_pend = 1'b0;
   logic [7:0] q_exp  = '0;

   // Monitor: DRIVE cycle checks ready/grant/J/K against the scoreboard head,
   // the following cycle checks the new bank state.
   always @(negedge clk) begin
      exp_t e;
      if (q_pend) begin
         chk("q_after", q, q_exp);
         chk("busy_idle", busy, 1'b0);
         chk("ready_idle", bus.req_ready, 4'b0000);
         q_pend <= 1'b0;
      end
      if (sb_en && busy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_grant: got grant %0d expected none", grant_id);
         end else begin
            e = sb.pop_front();
            chk("ready", bus.req_ready, e.ready);
            chk("grant", grant_id, e.grant);
            chk("j_out", j_out, e.j);
            chk("k_out", k_out, e.k);
            q_exp  <= e.q;
            q_pend <= 1'b1;
         end
      end
   end

   // Wait (bounded) for the DRIVE cycle; returns the latency in cycles.
   task automatic wait_busy(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 8);
      chk(name, busy, 1'b1);
   endtask

   task automatic do_req(input vec_t v);
      exp_t e;
      int   n;
      e.ready = v.ready; e.grant = v.grant; e.j = v.j; e.k = v.k; e.q = v.q;
      sb.push_back(e);
      bus.req_cmd[2*v.req +: 2]          = v.cmd;
      bus.req_mask[WIDTH*v.req +: WIDTH] = v.mask;
      bus.req_valid[v.req]               = 1'b1;
      wait_busy("req_timeout", n);
      if (busy) chk("latency", n, 1);
      else void'(sb.pop_front());
      bus.req_valid[v.req] = 1'b0;
      @(negedge clk);
   endtask

   vec_t vecs[9];

   initial begin
      int n;
      vecs[0] = '{1, 2'b10, 8'hFF, 4'b0010, 2'd1, 8'hFF, 8'h00, 8'hFF};
      vecs[1] = '{1, 2'b11, 8'h0F, 4'b0010, 2'd1, 8'h0F, 8'h0F, 8'hF0};
      vecs[2] = '{1, 2'b01, 8'h30, 4'b0010, 2'd1, 8'h00, 8'h30, 8'hC0};
      vecs[3] = '{2, 2'b01, 8'hFF, 4'b0100, 2'd2, 8'h00, 8'hFF, 8'h00};
      vecs[4] = '{2, 2'b10, 8'hA5, 4'b0100, 2'd2, 8'hA5, 8'h00, 8'hA5};
      vecs[5] = '{2, 2'b00, 8'hFF, 4'b0100, 2'd2, 8'h00, 8'h00, 8'hA5};
      vecs[6] = '{2, 2'b10, 8'h00, 4'b0100, 2'd2, 8'h00, 8'h00, 8'hA5};
      vecs[7] = '{0, 2'b11, 8'hFF, 4'b0001, 2'd0, 8'hFF, 8'hFF, 8'h5A};
      vecs[8] = '{3, 2'b10, 8'h0F, 4'b1000, 2'd3, 8'h0F, 8'h00, 8'h5F};

      // Reset held 3 cycles with every requester valid (hold commands).
      bus.req_cmd   = '0;
      bus.req_mask  = '0;
      bus.req_valid = '1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_q", q, 8'h00);
      chk("rst_j", j_out, 8'h00);
      chk("rst_k", k_out, 8'h00);
      chk("rst_ready", bus.req_ready, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant_id, 2'd0);

      // Contention: grants 0,1,2,3,0 on alternating cycles.
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k % 2 == 1) begin
            chk("cont_busy1", busy, 1'b1);
            chk("cont_grant", grant_id, ((k-1)/2) % 4);
            chk("cont_ready", bus.req_ready, 4'b0001 << (((k-1)/2) % 4));
         end else begin
            chk("cont_busy0", busy, 1'b0);
            chk("cont_ready0", bus.req_ready, 4'b0000);
         end
      end
      bus.req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Table-driven single commands.
      sb_en = 1'b1;
      foreach (vecs[i]) do_req(vecs[i]);
      sb_en = 1'b0;

      // Round-robin wrap: move pointer to 3, then req3 and req0 together.
      bus.req_cmd  = '0;
      bus.req_mask = '0;
      bus.req_valid = 4'b0100;
      wait_busy("wrap_pre_timeout", n);
      chk("wrap_pre_grant", grant_id, 2'd2);
      bus.req_valid = 4'b1001;
      @(negedge clk);
      wait_busy("wrap_timeout", n);
      chk("wrap_grant3", grant_id, 2'd3);
      chk("wrap_ready3", bus.req_ready, 4'b1000);
      bus.req_valid = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            chk("solo_busy1", busy, 1'b1);
            chk("solo_grant0", grant_id, 2'd0);
            chk("solo_ready", bus.req_ready, 4'b0001);
         end else begin
            chk("solo_busy0", busy, 1'b0);
            chk("solo_grant_hold", grant_id, (k == 1) ? 2'd3 : 2'd0);
         end
      end
      bus.req_valid = '0;
      @(negedge clk);
      chk("wrap_q_hold", q, 8'h5F);

      // Reset during DRIVE discards the pending set.
      bus.req_cmd[1:0]  = 2'b10;
      bus.req_mask[7:0] = 8'hFF;
      bus.req_valid     = 4'b0001;
      wait_busy("mid_timeout", n);
      chk("mid_j", j_out, 8'hFF);
      rst = 1'b1;
      bus.req_valid = '0;
      @(negedge clk);
      chk("mid_q", q, 8'h00);
      chk("mid_ready", bus.req_ready, 4'b0000);
      chk("mid_busy", busy, 1'b0);
      chk("mid_j0", j_out, 8'h00);
      chk("mid_k0", k_out, 8'h00);
      rst = 1'b0;
      bus.req_valid = 4'b0011;
      wait_busy("mid_re_timeout", n);
      chk("mid_regrant", grant_id, 2'd0);
      chk("mid_reready", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      @(negedge clk);
      chk("mid_req_q", q, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
